led_count_fixup: RTL



---
 rtl/led_count_fixup.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/led_count_fixup.sv
// -----------------------------------------------------------------------------
// led_count_fixup
//
// Takes the per-bin LED counts from the LED count calculation stage and
// corrects them so that they sum to exactly LEDS. A captured frame is summed
// serially, one bin per cycle. Any shortfall is then handed out one LED per
// cycle to bins that were non-zero on input. Any excess is trimmed one LED per
// cycle from bins that are still non-zero. The corrected vector is then
// presented with a one-cycle valid pulse. A frame whose counts are all zero
// passes through unchanged.
//
// Ports
//   clk        system clock
//   rst        synchronous, active-high reset
//   counts_i   raw per-bin counts, IW bits each (bin 0 at index 0)
//   data_v_i   single-cycle pulse: counts_i valid
//   counts_o   corrected counts, OW bits each; held between frames
//   data_v_o   single-cycle pulse: counts_o newly valid
//   busy       high whenever a frame is being processed
//   dropped    single-cycle pulse: a data_v_i arrived while busy and was lost
//   overflow   high together with data_v_o when the frame had to be trimmed
// -----------------------------------------------------------------------------
module led_count_fixup #(
  parameter int LEDS    = 50,
  parameter int BIN_QTY = 12,
  parameter int IW      = $clog2(LEDS),
  parameter int OW      = $clog2(LEDS + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [BIN_QTY-1:0][IW-1:0]    counts_i,
  input  logic                          data_v_i,
  output logic [BIN_QTY-1:0][OW-1:0]    counts_o,
  output logic                          data_v_o,
  output logic                          busy,
  output logic                          dropped,
  output logic                          overflow
);

  localparam int SW = $clog2(BIN_QTY * LEDS + 1);
  localparam int PW = (BIN_QTY > 1) ? $clog2(BIN_QTY) : 1;

  localparam logic [SW-1:0] LEDS_S   = SW'(LEDS);
  localparam logic [PW-1:0] LAST_BIN = PW'(BIN_QTY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SUM,
    S_EVAL,
    S_ADJUST,
    S_DONE
  } state_t;

  // Magnitude of the difference between the raw sum and the target
  function automatic logic [SW-1:0] abs_diff(input logic [SW-1:0] a,
                                             input logic [SW-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  // Control state (reset)
  state_t                       state_q,     state_d;
  logic [SW-1:0]                sum_q,       sum_d;
  logic [PW-1:0]                ptr_q,       ptr_d;
  logic [SW-1:0]                remaining_q, remaining_d;
  logic                         trim_q,      trim_d;
  logic [BIN_QTY-1:0][OW-1:0]   counts_o_q,  counts_o_d;
  logic                         data_v_o_q,  data_v_o_d;
  logic                         busy_q,      busy_d;
  logic                         dropped_q,   dropped_d;
  logic                         overflow_q,  overflow_d;

  // Working data (no reset: always loaded before use)
  logic [BIN_QTY-1:0][OW-1:0]   working_q,   working_d;
  logic [BIN_QTY-1:0]           mask_q,      mask_d;

  logic                         adj_upd;
  logic [PW-1:0]                ptr_inc;

  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    trim_d      = trim_q;
    counts_o_d  = counts_o_q;
    working_d   = working_q;
    mask_d      = mask_q;
    data_v_o_d  = 1'b0;
    overflow_d  = 1'b0;
    adj_upd     = 1'b0;

    // Any valid outside IDLE is lost, including during DONE
    dropped_d   = data_v_i && (state_q != S_IDLE);

    ptr_inc     = (ptr_q == LAST_BIN) ? '0 : ptr_q + PW'(1);

    case (state_q)
      S_IDLE: begin
        if (data_v_i) begin
          for (int i = 0; i < BIN_QTY; i++) begin
            working_d[i] = OW'(counts_i[i]);
            mask_d[i]    = (counts_i[i] != '0);
          end
          sum_d   = '0;
          ptr_d   = '0;
          state_d = S_SUM;
        end
      end

      S_SUM: begin
        sum_d = sum_q + SW'(working_q[ptr_q]);
        ptr_d = ptr_inc;
        if (ptr_q == LAST_BIN) begin
          state_d = S_EVAL;
        end
      end

      S_EVAL: begin
        remaining_d = abs_diff(sum_q, LEDS_S);
        trim_d      = (sum_q > LEDS_S);
        ptr_d       = '0;
        // An all-zero frame is legal silence and is passed through untouched
        if ((sum_q == LEDS_S) || (sum_q == '0)) begin
          state_d    = S_DONE;
          counts_o_d = working_q;
          data_v_o_d = 1'b1;
          overflow_d = 1'b0;
        end else begin
          state_d = S_ADJUST;
        end
      end

      S_ADJUST: begin
        // Add only to bins that were non-zero on input; trim only bins above 0.
        // Either way a bin with work to take always exists, so this terminates.
        adj_upd = trim_q ? (working_q[ptr_q] != '0) : mask_q[ptr_q];
        if (adj_upd) begin
          working_d[ptr_q] = trim_q ? (working_q[ptr_q] - OW'(1))
                                    : (working_q[ptr_q] + OW'(1));
          remaining_d      = remaining_q - SW'(1);
          if (remaining_q == SW'(1)) begin
            state_d    = S_DONE;
            counts_o_d = working_d;
            data_v_o_d = 1'b1;
            overflow_d = trim_q;
          end
        end
        ptr_d = ptr_inc;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sum_q       <= '0;
      ptr_q       <= '0;
      remaining_q <= '0;
      trim_q      <= 1'b0;
      counts_o_q  <= '0;
      data_v_o_q  <= 1'b0;
      busy_q      <= 1'b0;
      dropped_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      trim_q      <= trim_d;
      counts_o_q  <= counts_o_d;
      data_v_o_q  <= data_v_o_d;
      busy_q      <= busy_d;
      dropped_q   <= dropped_d;
      overflow_q  <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    working_q <= working_d;
    mask_q    <= mask_d;
  end

  assign counts_o = counts_o_q;
  assign data_v_o = data_v_o_q;
  assign busy     = busy_q;
  assign dropped  = dropped_q;
  assign overflow = overflow_q;

endmodule
